avalon_st_mult_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one Avalon-ST multiplier slave link among NUM_REQ requesters.
- For each granted request it:
  - streams operand packet A (header 0x01, then A MSB-first);
  - streams operand packet B (header 0x02, then B MSB-first);
  - collects the 8-byte result packet (MSB-first) and returns it to the granted requester.
- Sits between the operand-producing clients and the stream master/slave pair.

---
 rtl/avalon_st_mult_arbiter_if.sv | 24 ++
 rtl/avalon_st_mult_arbiter.sv | 115 +++++++++++
 tb/tb_avalon_st_mult_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/avalon_st_mult_arbiter_if.sv
// avalon_st_mult_arbiter_if: Avalon-ST source/sink pair between the arbiter and the multiplier slave
// Source (arbiter -> slave): valid_out, startofpacket_out, endofpacket_out, data_out; ready_in back.
// Sink (slave -> arbiter): valid_in, startofpacket_in, endofpacket_in, data_in; ready_out back.
// Modports: master = arbiter side, slave = multiplier side.
interface avalon_st_mult_arbiter_if;
  logic       ready_in;
  logic       valid_out;
  logic       startofpacket_out;
  logic       endofpacket_out;
  logic [7:0] data_out;
  logic       valid_in;
  logic       startofpacket_in;
  logic       endofpacket_in;
  logic [7:0] data_in;
  logic       ready_out;
  modport master (
    input  ready_in, valid_in, startofpacket_in, endofpacket_in, data_in,
    output valid_out, startofpacket_out, endofpacket_out, data_out, ready_out
  );
  modport slave (
    output ready_in, valid_in, startofpacket_in, endofpacket_in, data_in,
    input  valid_out, startofpacket_out, endofpacket_out, data_out, ready_out
  );
endinterface

// File: rtl/avalon_st_mult_arbiter.sv
// avalon_st_mult_arbiter: round-robin sharing of one Avalon-ST multiplier among NUM_REQ clients
// Clients: req/a_flat/b_flat in; grant (one-hot, whole transaction), done + res_valid pulse, res_out.
// Status: busy outside IDLE; err_out pulses on a result timeout when ARB_TIMEOUT_EN is defined.
// Stream: st (master modport) carries the operand source and the result sink.
// clk_in rising edge; rst asynchronous active-low.
module avalon_st_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [32*NUM_REQ-1:0]    a_flat,
  input  logic [32*NUM_REQ-1:0]    b_flat,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [63:0]              res_out,
  output logic                     res_valid,
  output logic                     busy,
  output logic                     err_out,
  avalon_st_mult_arbiter_if.master st
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_RES, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, win;
  logic any_req, sending, src_acc, src_last, snk_acc, res_last, tmo, err_r;
  logic [31:0] a_lat, b_lat;
  logic [2:0] beat, cnt;
  logic [55:0] acc;
  logic [39:0] pkt;
  // Scan downwards so the nearest requester after the pointer is written last and wins.
  always_comb begin
    any_req = 1'b0;
    win = ptr;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        any_req = 1'b1;
        win = PW'((int'(ptr) + k) % NUM_REQ);
      end
  end
  assign sending  = state == SEND_A || state == SEND_B;
  assign src_acc  = sending && st.ready_in;
  assign src_last = beat == 3'd4;
  assign snk_acc  = st.valid_in && st.ready_out;
  assign res_last = snk_acc && !st.startofpacket_in && cnt == 3'd7;
  // Header byte sits above the operand so beat n is simply byte 4-n of the packet.
  assign pkt = state == SEND_B ? {8'h02, b_lat} : {8'h01, a_lat};
  assign st.valid_out         = sending;
  assign st.startofpacket_out = sending && beat == 3'd0;
  assign st.endofpacket_out   = sending && src_last;
  assign st.data_out          = sending ? pkt[8*(4-int'(beat)) +: 8] : 8'h00;
  assign st.ready_out         = state == WAIT_RES;
  assign busy      = state != IDLE;
  assign res_valid = state == DONE && !err_r;
  assign err_out   = state == DONE && err_r;
  assign done      = state == DONE ? grant : '0;
`ifdef ARB_TIMEOUT_EN
  logic [31:0] tcnt;
  assign tmo = state == WAIT_RES && !snk_acc && tcnt == 32'(TIMEOUT - 1);
  always_ff @(posedge clk_in or negedge rst)
    if (!rst) tcnt <= '0;
    else tcnt <= state != WAIT_RES || snk_acc ? '0 : tcnt + 32'd1;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = any_req ? SEND_A : IDLE;
      SEND_A:   state_nx = src_acc && src_last ? SEND_B : SEND_A;
      SEND_B:   state_nx = src_acc && src_last ? WAIT_RES : SEND_B;
      WAIT_RES: state_nx = res_last || tmo ? DONE : WAIT_RES;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // Result bytes shift in MSB-first; the eighth byte completes res_out directly.
  always_ff @(posedge clk_in or negedge rst)
    if (!rst) begin
      ptr     <= PW'(NUM_REQ - 1);
      grant   <= '0;
      a_lat   <= '0;
      b_lat   <= '0;
      beat    <= '0;
      cnt     <= '0;
      acc     <= '0;
      res_out <= '0;
      err_r   <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        ptr   <= win;
        grant <= NUM_REQ'(1) << win;
        a_lat <= a_flat[32*win +: 32];
        b_lat <= b_flat[32*win +: 32];
        cnt   <= '0;
      end
      if (src_acc) beat <= src_last ? 3'd0 : beat + 3'd1;
      if (snk_acc) begin
        if (st.startofpacket_in) begin
          acc <= {48'd0, st.data_in};
          cnt <= 3'd1;
        end else if (cnt != 3'd0) begin
          acc <= {acc[47:0], st.data_in};
          cnt <= cnt + 3'd1;
        end
        if (st.endofpacket_in && !res_last) cnt <= 3'd0;
      end
      if (res_last) res_out <= {acc, st.data_in};
      if (state == WAIT_RES) err_r <= tmo;
      if (state == DONE) grant <= '0;
    end
endmodule

// File: tb/tb_avalon_st_mult_arbiter.sv
// tb_avalon_st_mult_arbiter: randomized bench against a round-robin and multiplier reference model
module tb_avalon_st_mult_arbiter;
  localparam int N = 4;
  logic clk_in = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [32*N-1:0] a_flat = '0, b_flat = '0;
  logic [N-1:0] grant, done;
  logic [63:0] res_out;
  logic res_valid, busy, err_out;
  logic [31:0] exp_a, exp_b;
  int n_chk = 0, n_err = 0, ptr = N - 1, g = 0;
  avalon_st_mult_arbiter_if st();
  avalon_st_mult_arbiter #(.NUM_REQ(N)) dut (
    .clk_in(clk_in), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .grant(grant), .done(done), .res_out(res_out), .res_valid(res_valid),
    .busy(busy), .err_out(err_out), .st(st)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic start_txn(input bit drop);
    int cyc = 0;
    g = -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && req[(ptr + k) % N]) g = (ptr + k) % N;
    if (g < 0) g = 0;
    exp_a = a_flat[32*g +: 32];
    exp_b = b_flat[32*g +: 32];
    st.ready_in = 1'b0;
    do begin
      @(negedge clk_in);
      cyc++;
    end while (grant == '0 && cyc < 8);
    check("grant", 64'(grant), 64'(1 << g));
    check("busy", 64'(busy), 64'd1);
    ptr = g;
    a_flat = {$urandom, $urandom, $urandom, $urandom};
    b_flat = {$urandom, $urandom, $urandom, $urandom};
    if (drop) req = 4'($urandom);
  endtask
  task automatic send_phase(input int mode, input int nb);
    logic [10:0] eb[10];
    logic [39:0] pa, pb;
    int idx = 0, cyc = 0, stall = 0;
    bit r;
    pa = {8'h01, exp_a};
    pb = {8'h02, exp_b};
    for (int i = 0; i < 5; i++) begin
      eb[i]   = {1'b1, i == 0, i == 4, pa[39-8*i -: 8]};
      eb[i+5] = {1'b1, i == 0, i == 4, pb[39-8*i -: 8]};
    end
    while (idx < nb && cyc < 300) begin
      r = mode == 1 || (mode == 2 ? !(idx == 2 && stall < 3) : $urandom_range(0, 2) != 0);
      if (mode == 2 && !r) stall++;
      st.ready_in = r;
      check("src_beat", 64'({st.valid_out, st.startofpacket_out, st.endofpacket_out, st.data_out}), 64'(eb[idx]));
      if (r) idx++;
      @(negedge clk_in);
      cyc++;
    end
    st.ready_in = 1'b0;
    check("src_count", 64'(idx), 64'(nb));
  endtask
  task automatic result_phase(input int rmode);
    logic [9:0] q[$];
    logic [63:0] p;
    int idx = 0, cyc = 0;
    bit v;
    p = 64'(exp_a) * 64'(exp_b);
    check("wait_ctl", 64'({st.valid_out, st.ready_out, busy}), 64'(3'b011));
    if (rmode == 1) begin
      q.push_back({2'b10, 8'h01});
      q.push_back({2'b01, 8'h02});
    end
    if (rmode == 2) begin
      q.push_back({2'b00, 8'($urandom)});
      q.push_back({2'b01, 8'($urandom)});
    end
    for (int i = 0; i < 8; i++) q.push_back({i == 0, i == 7, p[63-8*i -: 8]});
    while (idx < q.size() && cyc < 300) begin
      v = $urandom_range(0, 3) != 0;
      st.valid_in = v;
      {st.startofpacket_in, st.endofpacket_in, st.data_in} = v ? q[idx] : 10'($urandom);
      check("no_early_done", 64'({res_valid, done}), 64'd0);
      if (v && st.ready_out) idx++;
      @(negedge clk_in);
      cyc++;
    end
    st.valid_in = 1'b0;
    check("res_count", 64'(idx), 64'(q.size()));
    check("done_pulse", 64'({res_valid, err_out, busy, done, grant}), 64'({3'b101, 4'(1 << g), 4'(1 << g)}));
    check("res_out", res_out, p);
    @(negedge clk_in);
    check("back_idle", 64'({res_valid, err_out, busy, done, grant, st.valid_out, st.ready_out}), 64'd0);
    check("res_hold", res_out, p);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    st.ready_in = 1'b0;
    st.valid_in = 1'b0;
    st.startofpacket_in = 1'b0;
    st.endofpacket_in = 1'b0;
    st.data_in = 8'h00;
    repeat (3) @(negedge clk_in);
    check("rst_ctl", 64'({grant, done, res_valid, busy, err_out, st.valid_out,
                          st.startofpacket_out, st.endofpacket_out, st.ready_out}), 64'd0);
    check("rst_data", 64'(st.data_out), 64'd0);
    check("rst_res", res_out, 64'd0);
    rst = 1'b1;
    req = 4'hf;
    for (int t = 0; t < 5; t++) begin
      start_txn(0);
      check("rr_order", 64'(grant), 64'(1 << (t % 4)));
      send_phase(0, 10);
      result_phase(0);
    end
    req = 4'b0001;
    a_flat[31:0] = 32'h12345678;
    b_flat[31:0] = 32'h00000002;
    start_txn(0);
    send_phase(1, 10);
    result_phase(0);
    check("res_directed", res_out, 64'h00000000_2468acf0);
    a_flat[31:0] = 32'h12345678;
    b_flat[31:0] = $urandom;
    start_txn(0);
    send_phase(2, 10);
    result_phase(0);
    req = 4'b0100;
    a_flat[95:64] = 32'd1;
    b_flat[95:64] = 32'd5;
    start_txn(0);
    send_phase(1, 10);
    result_phase(1);
    check("res_partial", res_out, 64'd5);
    for (int t = 0; t < 25; t++) begin
      req = 4'($urandom_range(1, 15));
      start_txn(1);
      send_phase(0, 10);
      result_phase(int'($urandom_range(0, 2)));
    end
    req = 4'b0001;
    start_txn(0);
    send_phase(1, 6);
    rst = 1'b0;
    #1;
    check("midrst_ctl", 64'({grant, done, res_valid, busy, err_out, st.valid_out,
                             st.startofpacket_out, st.endofpacket_out, st.ready_out}), 64'd0);
    check("midrst_data", 64'(st.data_out), 64'd0);
    check("midrst_res", res_out, 64'd0);
    @(negedge clk_in);
    req = 4'b0110;
    rst = 1'b1;
    ptr = N - 1;
    start_txn(0);
    check("rst_regrant", 64'(grant), 64'(4'b0010));
    send_phase(0, 10);
    result_phase(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
